// File: rtl/legv8_pkg.sv
// Shared LEGv8 execute-stage definitions: ALU function selects, status bit
// positions and the multiply sequencer state type.
package legv8_pkg;

  // FS[4:2] picks the operation; FS[1]/FS[0] invert A/B.
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_SHL = 5'b10000;
  localparam logic [4:0] FS_SHR = 5'b10100;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } mul_state_t;

endpackage

// File: rtl/legv8_mul_sequencer.sv
// Shift-add 64x64 unsigned multiplier that borrows the shared LEGv8 ALU.
// Optional MUL_EARLY_EXIT_EN stops iterating once the remaining multiplier is zero.
module legv8_mul_sequencer
  import legv8_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] multiplicand,
  input  logic [63:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic        overflow,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [4:0]  alu_fs,
  output logic        alu_cin,
  input  logic [63:0] alu_f,
  input  logic [3:0]  alu_status
);

  mul_state_t  state_r;
  logic [63:0] acc_r;
  logic [63:0] mcand_r;
  logic [63:0] mplr_r;
  logic [6:0]  cnt_r;
  logic        ovf_r;

  logic [63:0] mplr_shr_s;
  logic        lost_bit_s;
  logic        last_shift_s;
  logic        zero_exit_s;
  logic        unused_status_s;

  assign mplr_shr_s = {1'b0, mplr_r[63:1]};
  // A multiplicand bit shifted out still matters if a later multiplier bit will add it.
  assign lost_bit_s = mcand_r[63] & (mplr_shr_s != 64'd0);

`ifdef MUL_EARLY_EXIT_EN
  assign last_shift_s = (cnt_r == 7'd63) || (mplr_shr_s == 64'd0);
  assign zero_exit_s  = (multiplier == 64'd0);
`else
  assign last_shift_s = (cnt_r == 7'd63);
  assign zero_exit_s  = 1'b0;
`endif

  assign unused_status_s = ^{alu_status[ST_V], alu_status[ST_N], alu_status[ST_Z]};

  assign product  = acc_r;
  assign overflow = ovf_r;

  // Sequencer FSM; ALU drives are registered on entry to the state that uses them.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
      acc_r   <= 64'd0;
      mcand_r <= 64'd0;
      mplr_r  <= 64'd0;
      cnt_r   <= 7'd0;
      ovf_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_a   <= 64'd0;
      alu_b   <= 64'd0;
      alu_fs  <= 5'd0;
      alu_cin <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done    <= 1'b0;
          alu_cin <= 1'b0;
          if (start) begin
            acc_r   <= 64'd0;
            ovf_r   <= 1'b0;
            mcand_r <= multiplicand;
            mplr_r  <= multiplier;
            cnt_r   <= 7'd0;
            if (zero_exit_s) begin
              state_r <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              alu_a   <= 64'd0;
              alu_b   <= 64'd0;
              alu_fs  <= 5'd0;
            end else if (multiplier[0]) begin
              state_r <= S_ADD;
              busy    <= 1'b1;
              alu_a   <= 64'd0;
              alu_b   <= multiplicand;
              alu_fs  <= FS_ADD;
            end else begin
              state_r <= S_SHIFT;
              busy    <= 1'b1;
              alu_a   <= multiplicand;
              alu_b   <= 64'd1;
              alu_fs  <= FS_SHL;
            end
          end else begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
            alu_a   <= 64'd0;
            alu_b   <= 64'd0;
            alu_fs  <= 5'd0;
          end
        end

        S_ADD: begin
          acc_r   <= alu_f;
          ovf_r   <= ovf_r | alu_status[ST_C];
          state_r <= S_SHIFT;
          busy    <= 1'b1;
          done    <= 1'b0;
          alu_a   <= mcand_r;
          alu_b   <= 64'd1;
          alu_fs  <= FS_SHL;
          alu_cin <= 1'b0;
        end

        S_SHIFT: begin
          mcand_r <= alu_f;
          mplr_r  <= mplr_shr_s;
          cnt_r   <= cnt_r + 7'd1;
          ovf_r   <= ovf_r | lost_bit_s;
          alu_cin <= 1'b0;
          if (last_shift_s) begin
            state_r <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            alu_a   <= 64'd0;
            alu_b   <= 64'd0;
            alu_fs  <= 5'd0;
          end else if (mplr_r[1]) begin
            // The freshly shifted multiplicand is on alu_f this cycle.
            state_r <= S_ADD;
            busy    <= 1'b1;
            done    <= 1'b0;
            alu_a   <= acc_r;
            alu_b   <= alu_f;
            alu_fs  <= FS_ADD;
          end else begin
            state_r <= S_SHIFT;
            busy    <= 1'b1;
            done    <= 1'b0;
            alu_a   <= alu_f;
            alu_b   <= 64'd1;
            alu_fs  <= FS_SHL;
          end
        end

        S_DONE: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          alu_a   <= 64'd0;
          alu_b   <= 64'd0;
          alu_fs  <= 5'd0;
          alu_cin <= 1'b0;
        end

        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          alu_a   <= 64'd0;
          alu_b   <= 64'd0;
          alu_fs  <= 5'd0;
          alu_cin <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_mul_sequencer.sv
// Bench for legv8_mul_sequencer: models the shared ALU, checks products against
// 128-bit arithmetic and busy length against popcount (honours MUL_EARLY_EXIT_EN).
module tb_legv8_mul_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        overflow;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [4:0]  alu_fs;
  logic        alu_cin;
  logic [63:0] alu_f;
  logic [3:0]  alu_status;

  int n_checks = 0;
  int n_pass   = 0;

  legv8_mul_sequencer dut (
    .clock(clock), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product), .overflow(overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fs(alu_fs), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_status(alu_status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural stand-in for the parent's LEGv8 ALU.
  logic [63:0] am_s, bm_s;
  logic [64:0] sum_s;
  logic        c_s, v_s;
  always_comb begin
    am_s  = alu_fs[1] ? ~alu_a : alu_a;
    bm_s  = alu_fs[0] ? ~alu_b : alu_b;
    sum_s = {1'b0, am_s} + {1'b0, bm_s} + {64'd0, alu_cin};
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (alu_fs[4:2])
      3'b000: alu_f = am_s & bm_s;
      3'b001: alu_f = am_s | bm_s;
      3'b010: begin
        alu_f = sum_s[63:0];
        c_s   = sum_s[64];
        v_s   = (am_s[63] == bm_s[63]) && (sum_s[63] != am_s[63]);
      end
      3'b011: alu_f = am_s ^ bm_s;
      3'b100: alu_f = am_s << bm_s[5:0];
      3'b101: alu_f = am_s >> bm_s[5:0];
      default: alu_f = 64'd0;
    endcase
    alu_status = {v_s, c_s, alu_f[63], (alu_f == 64'd0)};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
  endtask

  function automatic int exp_busy(input logic [63:0] b);
    int msb;
    msb = -1;
    for (int i = 0; i < 64; i++) if (b[i]) msb = i;
`ifdef MUL_EARLY_EXIT_EN
    return (msb + 1) + $countones(b);
`else
    return 64 + $countones(b);
`endif
  endfunction

  task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input bit poke,
                         input string tag);
    logic [127:0] full;
    int busy_cyc, budget, dones;
    full = {64'd0, a} * {64'd0, b};
    busy_cyc = 0; budget = 0; dones = 0;
    @(negedge clock);
    start = 1'b1; multiplicand = a; multiplier = b;
    @(negedge clock);
    start = 1'b0;
    while (!done && budget < 300) begin
      if (busy) busy_cyc++;
      // Stray request mid-operation with different operands.
      start = poke && (busy_cyc == 3);
      multiplicand = start ? ~a : a;
      multiplier   = start ? (b ^ 64'h5) : b;
      @(negedge clock);
      budget++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {63'd0, done}, 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_busy(b)));
    check({tag, "_product"}, product, full[63:0]);
    check({tag, "_overflow"}, {63'd0, overflow}, {63'd0, (full[127:64] != 64'd0)});
    @(negedge clock);
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, "_product_held"}, product, full[63:0]);
    if (poke) begin
      for (int i = 0; i < 150; i++) begin
        if (done) dones++;
        @(negedge clock);
      end
      check({tag, "_no_extra_done"}, 64'(dones), 64'd0);
      check({tag, "_product_kept"}, product, full[63:0]);
    end
  endtask

  initial begin
    logic [63:0] ra, rb;
    int dones;
    reset = 1'b1; start = 1'b0; multiplicand = 64'd0; multiplier = 64'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_alu", {alu_a ^ alu_b, 58'd0, alu_fs, alu_cin}, 64'd0);
    check("rst_alu_a", alu_a, 64'd0);
    reset = 1'b0;

    run_mul(64'd3, 64'd5, 1'b0, "m3x5");
    check("idle_alu_a", alu_a, 64'd0);
    check("idle_alu_fs", {59'd0, alu_fs}, 64'd0);
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "ones_x1");
    run_mul(64'h1_0000_0000, 64'h1_0000_0000, 1'b0, "p32xp32");
    run_mul(64'h8000_0000_0000_0001, 64'd2, 1'b0, "msb_x2");
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, "ones_x3");
    run_mul(64'h1234, 64'd0, 1'b0, "x_zero");
    run_mul(64'd3, 64'd5, 1'b1, "poke");

    for (int k = 0; k < 12; k++) begin
      ra = {$urandom, $urandom} >> $urandom_range(0, 63);
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_mul(ra, rb, 1'b0, $sformatf("rnd%0d", k));
    end

    // Abort mid-operation with a synchronous reset.
    @(negedge clock);
    start = 1'b1; multiplicand = 64'h123; multiplier = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    check("abort_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_overflow", {63'd0, overflow}, 64'd0);
    check("abort_alu_a", alu_a, 64'd0);
    check("abort_alu_b", alu_b, 64'd0);
    check("abort_alu_ctl", {58'd0, alu_fs, alu_cin}, 64'd0);
    dones = 0;
    for (int i = 0; i < 150; i++) begin
      if (done || busy) dones++;
      @(negedge clock);
    end
    check("abort_quiet", 64'(dones), 64'd0);
    run_mul(64'd7, 64'd6, 1'b0, "m7x6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/legv8_mul_sequencer.md
# legv8_mul_sequencer

Multi-cycle unsigned 64x64 multiplier controller that borrows the shared LEGv8 64-bit ALU. It holds no adder of its own: it drives the ALU's A, B, FS and Cin operands each cycle and captures F and status back. It implements shift-add multiplication, returning the low 64 product bits plus an overflow flag. It sits beside the ALU in the execute stage; the parent muxes the ALU operand inputs to this block while `busy` is high.

## Interface
- No parameters; width fixed at 64.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `multiplicand`  in  64  operand A; sampled with `start`.
- `multiplier`  in  64  operand B; sampled with `start`.
- `busy`  out  1  high in ADD and SHIFT states.
- `done`  out  1  one-cycle pulse; `product`/`overflow` valid.
- `product`  out  64  low 64 bits of result; held until next accepted `start`.
- `overflow`  out  1  true product ≥ 2^64; held with `product`.
- `alu_a`, `alu_b`  out  64  ALU operand drives.
- `alu_fs`  out  5  ALU function select.
- `alu_cin`  out  1  ALU carry in.
- `alu_f`  in  64  ALU result.
- `alu_status`  in  4  ALU flags {V, C, N, Z}; bit 2 = carry out.

## Operation
- ALU FS encoding: FS[4:2] selects 000 AND, 001 OR, 010 ADD, 011 XOR, 100 SHL, 101 SHR. FS[1] inverts A; FS[0] inverts B. The block uses ADD = 5'b01000 and SHL = 5'b10000 (shift amount = `alu_b[5:0]`).
- Internal registers:
  - `acc` (64): drives `product`.
  - `mcand` (64).
  - `mplr` (64).
  - `cnt` (7).
  - `ovf`: sticky; drives `overflow`.
- States: IDLE, ADD, SHIFT, DONE.
- IDLE:
  - ALU outputs are all 0.
  - On `start`: acc←0, ovf←0, mcand←multiplicand, mplr←multiplier, cnt←0.
  - Next state is ADD if multiplier[0], else SHIFT.
- ADD:
  - alu_a=acc, alu_b=mcand, alu_fs=ADD, alu_cin=0.
  - acc←alu_f; ovf|=alu_status[2].
  - Next state: SHIFT.
- SHIFT:
  - alu_a=mcand, alu_b=1, alu_fs=SHL, alu_cin=0.
  - mcand←alu_f; mplr←mplr>>1; cnt←cnt+1.
  - ovf|=mcand[63] & (mplr>>1 ≠ 0), because a lost bit would still be added later.
  - If cnt==63, next state is DONE. Otherwise next state is ADD if mplr[1], else SHIFT.
- DONE: `done`=1 for one cycle, then IDLE. `start` is ignored in DONE.
- `start` is ignored in ADD, SHIFT and DONE; no queuing.
- Arithmetic is unsigned modulo 2^64. Signed-operand callers use `product` only and ignore `overflow`.

## Timing
- Reset values: state IDLE, busy 0, done 0, product 0, overflow 0, alu_a/alu_b 0, alu_fs 0, alu_cin 0.
- Reset asserted mid-operation aborts on the next edge to the reset values. No `done` pulse is produced.
- ALU is combinational; every ADD/SHIFT state consumes exactly one cycle.
- Latency with `start` accepted at edge 0:
  - `busy` is high for 64 + popcount(multiplier) cycles.
  - `done` is high in the following cycle.
- `product`/`overflow` change only at the ADD/SHIFT edges and on an accepted `start`. They are stable from `done` until the next accepted `start`.

## Configuration
- `MUL_EARLY_EXIT_EN` defined:
  - In SHIFT, if mplr>>1 == 0, go to DONE regardless of `cnt`.
  - In IDLE, a `start` with multiplier==0 goes directly to DONE: zero busy cycles, `done` the cycle after `start`.
  - Busy cycles = (index of highest set bit + 1) + popcount.
- Undefined: always 64 SHIFT iterations; latency is as in Timing.
- `product` and `overflow` are identical in both builds.

## Structure
- Shared package `legv8_pkg` holds:
  - FS constants `FS_AND`, `FS_OR`, `FS_ADD`, `FS_XOR`, `FS_SHL`, `FS_SHR`.
  - The status bit index constants `ST_Z=0`, `ST_N=1`, `ST_C=2`, `ST_V=3`.
  - The `mul_state_t` enum.
- No sub-module. The ALU is instantiated in the parent, and its operand mux is owned there.

## Test plan
- 3 × 5 → product 15, overflow 0. Busy 66 cycles without the macro; 5 cycles with it.
- 0xFFFF_FFFF_FFFF_FFFF × 1 → product 0xFFFF_FFFF_FFFF_FFFF, overflow 0.
- 2^32 × 2^32 → product 0, overflow 1 (bit lost by SHL while the multiplier is still nonzero).
- 0x8000_0000_0000_0001 × 2 → product 2, overflow 1. Also 0xFFFF_FFFF_FFFF_FFFF × 3 → product 0xFFFF_FFFF_FFFF_FFFD, overflow 1 (ADD carry path).
- `start` pulsed again while busy with different operands → ignored; the first result is unchanged; exactly one `done`.
- `reset` asserted at busy cycle 10 → next cycle all outputs at reset values, no `done`. A following 7 × 6 → 42.
